phase_coincidence_scorer: RTL and testbench
===========================================

Name: phase_coincidence_scorer

Overview:
- Consumes the per-cycle phase results of a bank of phase-coding neurons: one query neuron plus N_KEYS key neurons.
- At each gamma cycle boundary it snapshots every neuron's locked phase and fired flag.
- It then scans the keys sequentially, one per clock, and computes a phase-coincidence relevance score for each query/key pair.
- It reports the per-key scores, a match mask and the winning key (argmax) over a valid/ready handshake. This is the attention stage that sits directly after the neuron bank.

Parameters:
- N_KEYS, 4, number of key neurons scored per cycle; legal range 2..16.
- WINDOW, 8'd32, coincidence window in phase units; legal range 1..255.
- IDX_W, $clog2(N_KEYS), derived localparam, width of the key index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cycle_start  in  1  gamma-cycle start pulse, same pulse that drives the neurons.
- q_phase  in  8  query neuron locked phase.
- q_fired  in  1  query neuron fired-this-cycle flag.
- k_phase  in  N_KEYS*8  key locked phases; key i occupies bits [8i+7:8i].
- k_fired  in  N_KEYS  key fired flags.
- out_ready  in  1  downstream accepts the result.
- out_valid  out  1  result available.
- best_idx  out  IDX_W  index of the highest-scoring key.
- best_score  out  8  score of best_idx.
- score_bus  out  N_KEYS*8  per-key scores, same packing as k_phase.
- match_mask  out  N_KEYS  bit i set when score_i > 0.
- busy  out  1  high in SCAN or DONE.
- overrun  out  1  one-clock pulse when a snapshot is dropped.

Behaviour:
- Reset: all outputs 0. State IDLE, snapshot registers 0.
- Snapshot:
  - Taken at the clock edge where cycle_start is sampled high; the neuron outputs still hold the previous cycle's results at that edge.
  - Registers q_phase, q_fired, k_phase and k_fired.
  - Clears score_bus, match_mask, best_idx, best_score and the scan index.
- States:
  - IDLE: cycle_start → snapshot, go to SCAN.
  - SCAN: evaluates key idx at each edge, idx = 0..N_KEYS-1. After idx = N_KEYS-1 is evaluated, go to DONE and set out_valid = 1.
  - DONE: out_valid held high and all result outputs held stable until out_valid && out_ready. On that handshake, clear out_valid and go to IDLE.
- Latency: the cycle_start edge is T0; key i is evaluated at edge T0+1+i; out_valid is high after edge T0+N_KEYS.
- Score for key i:
  - If q_fired && k_fired[i]: diff = |q_phase − k_phase_i|, an 8-bit unsigned absolute difference with no circular wrap (phases 0 and 255 are 255 apart). score = (diff < WINDOW) ? WINDOW − diff : 0.
  - Otherwise score = 0.
  - Result is 8 bits; it cannot overflow.
- Argmax:
  - A key replaces the best only if its score is strictly greater, so ties keep the lowest index.
  - If no key matches: best_idx = 0, best_score = 0, match_mask = 0, and out_valid is still asserted.
- cycle_start while in SCAN or DONE with no handshake in that clock: snapshot dropped, overrun = 1 for one clock, current operation and outputs unaffected.
- cycle_start in the same clock as the DONE handshake: the handshake completes, a new snapshot is taken, next state is SCAN, out_valid = 0 next clock, no overrun.
- Input changes after the snapshot have no effect on the current scan.
- rst_n asserted mid-SCAN or mid-DONE: immediate return to reset values; the partial result is discarded.

Decomposition:
- Shared package pst_pkg holds:
  - PHASE_W = 8, SCORE_W = 8;
  - PHASE_NOFIRE = 8'd255;
  - scorer state enum {IDLE, SCAN, DONE}.
- One combinational sub-module, phase_score: inputs two phases, two fired flags and WINDOW; output an 8-bit score. It is reusable by later multi-head stages.
- The FSM, snapshot registers, scan counter and argmax register stay in the top module.

Test Plan (N_KEYS = 4, WINDOW = 32):
- Basic scoring: q = 100 fired; keys 100/110/140/90, all fired, one cycle_start → after 4 clocks out_valid = 1; score_bus = 32/22/0/22; match_mask = 4'b1011; best_idx = 0; best_score = 32.
- Tie-break: q = 50; keys 200/40/0/60 fired; k_fired = 4'b1010 → scores 0/22/0/22; best_idx = 1; best_score = 22; match_mask = 4'b1010.
- No-fire and no-wrap:
  - q_fired = 0 → all scores 0, mask 0, best 0/0, out_valid still asserted.
  - Separately, q = 2, key0 = 254 → score0 = 0 (no circular wrap).
- Backpressure/overrun: out_ready = 0 for 10 clocks, cycle_start in the 3rd DONE clock → overrun pulses once; outputs unchanged; out_ready = 1 → IDLE, out_valid = 0.
- Back-to-back: cycle_start in the same clock as the handshake → no overrun; SCAN restarts; new result valid 4 clocks later.
- Reset mid-SCAN: assert rst_n low at scan idx 2 → all outputs 0 immediately; next cycle_start produces a correct full result.

Source files
------------

// File: rtl/phase_coincidence_scorer_pkg.sv
// Shared types and widths for the phase-coincidence attention stage.
package pst_pkg;

   localparam int PHASE_W = 8;
   localparam int SCORE_W = 8;

   // Phase value a neuron reports when it did not fire this gamma cycle.
   localparam logic [PHASE_W-1:0] PHASE_NOFIRE = 8'd255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } pst_state_e;

endpackage

// File: rtl/phase_coincidence_scorer_phase_score.sv
// Combinational relevance score for one query/key phase pair.
module phase_score
   import pst_pkg::*;
(
   input  logic [PHASE_W-1:0] i_phase_a,
   input  logic [PHASE_W-1:0] i_phase_b,
   input  logic               i_fired_a,
   input  logic               i_fired_b,
   input  logic [PHASE_W-1:0] i_window,
   output logic [SCORE_W-1:0] o_score
);

   logic [PHASE_W-1:0] w_diff;
   logic               w_hit;

   // Linear distance: phases are not treated as circular.
   assign w_diff = (i_phase_a >= i_phase_b) ? (i_phase_a - i_phase_b)
                                            : (i_phase_b - i_phase_a);

   assign w_hit   = i_fired_a && i_fired_b && (w_diff < i_window);
   assign o_score = w_hit ? SCORE_W'(i_window - w_diff) : '0;

endmodule

// File: rtl/phase_coincidence_scorer.sv
// Snapshots the neuron bank each gamma cycle, scores keys one per clock
// against the query, and presents scores, match mask and argmax via valid/ready.
module phase_coincidence_scorer
   import pst_pkg::*;
#(
   parameter  int                 N_KEYS = 4,
   parameter  logic [PHASE_W-1:0] WINDOW = 8'd32,
   localparam int                 IDX_W  = $clog2(N_KEYS)
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_cycle_start,
   input  logic [PHASE_W-1:0]          i_q_phase,
   input  logic                        i_q_fired,
   input  logic [N_KEYS*PHASE_W-1:0]   i_k_phase,
   input  logic [N_KEYS-1:0]           i_k_fired,
   input  logic                        i_out_ready,
   output logic                        o_out_valid,
   output logic [IDX_W-1:0]            o_best_idx,
   output logic [SCORE_W-1:0]          o_best_score,
   output logic [N_KEYS*SCORE_W-1:0]   o_score_bus,
   output logic [N_KEYS-1:0]           o_match_mask,
   output logic                        o_busy,
   output logic                        o_overrun
);

   // state | meaning
   // IDLE  | waiting for a gamma-cycle start, no result pending
   // SCAN  | scoring snapshot key r_idx this clock
   // DONE  | result presented, held until out_valid && out_ready

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_KEYS - 1);

   pst_state_e                 r_state;
   logic [IDX_W-1:0]           r_idx;

   logic [PHASE_W-1:0]         r_q_phase;
   logic                       r_q_fired;
   logic [N_KEYS*PHASE_W-1:0]  r_k_phase;
   logic [N_KEYS-1:0]          r_k_fired;

   logic                       r_out_valid;
   logic [IDX_W-1:0]           r_best_idx;
   logic [SCORE_W-1:0]         r_best_score;
   logic [N_KEYS*SCORE_W-1:0]  r_score_bus;
   logic [N_KEYS-1:0]          r_match_mask;
   logic                       r_busy;
   logic                       r_overrun;

   logic                       w_handshake;
   logic                       w_snap;
   logic [PHASE_W-1:0]         w_k_arr [N_KEYS];
   logic [PHASE_W-1:0]         w_k_phase_sel;
   logic                       w_k_fired_sel;
   logic [SCORE_W-1:0]         w_score;

   assign w_handshake = (r_state == DONE) && r_out_valid && i_out_ready;
   assign w_snap      = i_cycle_start && ((r_state == IDLE) || w_handshake);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_unpack
      assign w_k_arr[g] = r_k_phase[g*PHASE_W +: PHASE_W];
   end

   assign w_k_phase_sel = w_k_arr[r_idx];
   assign w_k_fired_sel = r_k_fired[r_idx];

   phase_score u_phase_score (
      .i_phase_a (r_q_phase),
      .i_phase_b (w_k_phase_sel),
      .i_fired_a (r_q_fired),
      .i_fired_b (w_k_fired_sel),
      .i_window  (WINDOW),
      .o_score   (w_score)
   );

   // Snapshot is only taken when the FSM accepts a new cycle, so later
   // input changes cannot disturb a scan in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q_phase <= '0;
         r_q_fired <= 1'b0;
         r_k_phase <= '0;
         r_k_fired <= '0;
      end else if (w_snap) begin
         r_q_phase <= i_q_phase;
         r_q_fired <= i_q_fired;
         r_k_phase <= i_k_phase;
         r_k_fired <= i_k_fired;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_out_valid  <= 1'b0;
         r_best_idx   <= '0;
         r_best_score <= '0;
         r_score_bus  <= '0;
         r_match_mask <= '0;
         r_busy       <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_snap) begin
            r_state      <= SCAN;
            r_idx        <= '0;
            r_out_valid  <= 1'b0;
            r_best_idx   <= '0;
            r_best_score <= '0;
            r_score_bus  <= '0;
            r_match_mask <= '0;
            r_busy       <= 1'b1;
         end else begin
            case (r_state)
               IDLE: begin
                  r_busy <= 1'b0;
               end
               SCAN: begin
                  r_overrun                                <= i_cycle_start;
                  r_score_bus[r_idx*SCORE_W +: SCORE_W]    <= w_score;
                  r_match_mask[r_idx]                      <= |w_score;
                  // Strictly greater keeps the lowest index on ties.
                  if (w_score > r_best_score) begin
                     r_best_score <= w_score;
                     r_best_idx   <= r_idx;
                  end
                  if (r_idx == LAST_IDX) begin
                     r_state     <= DONE;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
               DONE: begin
                  if (w_handshake) begin
                     r_state     <= IDLE;
                     r_out_valid <= 1'b0;
                     r_busy      <= 1'b0;
                  end else begin
                     r_overrun <= i_cycle_start;
                  end
               end
               default: begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_out_valid  = r_out_valid;
   assign o_best_idx   = r_best_idx;
   assign o_best_score = r_best_score;
   assign o_score_bus  = r_score_bus;
   assign o_match_mask = r_match_mask;
   assign o_busy       = r_busy;
   assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_phase_coincidence_scorer.sv
// Self-checking bench for phase_coincidence_scorer (4 keys, window 32).
module tb_phase_coincidence_scorer;
   import pst_pkg::*;

   localparam int NK = 4;

   typedef struct {
      logic [7:0]  q;
      logic        qf;
      logic [31:0] kp;
      logic [3:0]  kf;
      logic [31:0] sb;
      logic [3:0]  mask;
      logic [1:0]  idx;
      logic [7:0]  best;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_cycle_start = 1'b0;
   logic [7:0]  i_q_phase = '0;
   logic        i_q_fired = 1'b0;
   logic [31:0] i_k_phase = '0;
   logic [3:0]  i_k_fired = '0;
   logic        i_out_ready = 1'b0;
   logic        o_out_valid;
   logic [1:0]  o_best_idx;
   logic [7:0]  o_best_score;
   logic [31:0] o_score_bus;
   logic [3:0]  o_match_mask;
   logic        o_busy;
   logic        o_overrun;

   int n_checks = 0;
   int n_errors = 0;
   vec_t tbl [5];

   always #5 clk = ~clk;

   phase_coincidence_scorer #(.N_KEYS(NK), .WINDOW(8'd32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_cycle_start(i_cycle_start),
      .i_q_phase    (i_q_phase),
      .i_q_fired    (i_q_fired),
      .i_k_phase    (i_k_phase),
      .i_k_fired    (i_k_fired),
      .i_out_ready  (i_out_ready),
      .o_out_valid  (o_out_valid),
      .o_best_idx   (o_best_idx),
      .o_best_score (o_best_score),
      .o_score_bus  (o_score_bus),
      .o_match_mask (o_match_mask),
      .o_busy       (o_busy),
      .o_overrun    (o_overrun)
   );

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: linear phase distance, coincidence window 32, strict-greater argmax.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int best;
      r = v;
      best = 0;
      r.sb = '0;
      r.mask = '0;
      r.idx = '0;
      for (int i = 0; i < NK; i++) begin
         int d;
         int s;
         d = int'(v.q) - int'(v.kp[8*i +: 8]);
         if (d < 0) d = -d;
         s = (v.qf && v.kf[i] && d < 32) ? 32 - d : 0;
         r.sb[8*i +: 8] = 8'(s);
         r.mask[i] = (s > 0);
         if (s > best) begin
            best = s;
            r.idx = 2'(i);
         end
      end
      r.best = 8'(best);
      return r;
   endfunction

   task automatic scramble();
      i_q_phase = 8'($urandom);
      i_q_fired = 1'($urandom);
      i_k_phase = $urandom;
      i_k_fired = 4'($urandom);
   endtask

   task automatic start(input vec_t v);
      i_q_phase = v.q;
      i_q_fired = v.qf;
      i_k_phase = v.kp;
      i_k_fired = v.kf;
      i_cycle_start = 1'b1;
      tick();
      i_cycle_start = 1'b0;
      scramble();
   endtask

   task automatic wait_result(input vec_t v, input string tag, input int n0);
      int n;
      n = n0;
      while (!o_out_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 48'(n), 48'd4);
      chk({tag, "_score_bus"}, 48'(o_score_bus), 48'(v.sb));
      chk({tag, "_mask"}, 48'(o_match_mask), 48'(v.mask));
      chk({tag, "_best_idx"}, 48'(o_best_idx), 48'(v.idx));
      chk({tag, "_best_score"}, 48'(o_best_score), 48'(v.best));
      chk({tag, "_busy"}, 48'(o_busy), 48'd1);
   endtask

   task automatic handshake(input string tag);
      i_out_ready = 1'b1;
      tick();
      i_out_ready = 1'b0;
      chk({tag, "_valid_clr"}, 48'(o_out_valid), 48'd0);
      chk({tag, "_busy_clr"}, 48'(o_busy), 48'd0);
   endtask

   function automatic logic [47:0] all_outs();
      return 48'({o_out_valid, o_busy, o_overrun, o_best_idx, o_best_score,
                  o_score_bus, o_match_mask});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   ovr;

      tbl[0] = '{q: 8'd100, qf: 1'b1, kp: {8'd90, 8'd140, 8'd110, 8'd100}, kf: 4'hF,
                 sb: {8'd22, 8'd0, 8'd22, 8'd32}, mask: 4'b1011, idx: 2'd0, best: 8'd32};
      tbl[1] = '{q: 8'd50, qf: 1'b1, kp: {8'd60, 8'd0, 8'd40, 8'd200}, kf: 4'b1010,
                 sb: {8'd22, 8'd0, 8'd22, 8'd0}, mask: 4'b1010, idx: 2'd1, best: 8'd22};
      tbl[2] = '{q: 8'd100, qf: 1'b0, kp: {8'd90, 8'd140, 8'd110, 8'd100}, kf: 4'hF,
                 sb: 32'd0, mask: 4'b0000, idx: 2'd0, best: 8'd0};
      tbl[3] = '{q: 8'd2, qf: 1'b1, kp: {8'd34, 8'd33, 8'd2, 8'd254}, kf: 4'hF,
                 sb: {8'd0, 8'd1, 8'd32, 8'd0}, mask: 4'b0110, idx: 2'd1, best: 8'd32};
      tbl[4] = '{q: 8'd255, qf: 1'b1, kp: {8'd224, 8'd255, 8'd255, 8'd0}, kf: 4'hF,
                 sb: {8'd1, 8'd32, 8'd32, 8'd0}, mask: 4'b1110, idx: 2'd1, best: 8'd32};

      repeat (2) tick();
      chk("reset_outputs", all_outs(), 48'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_outputs", all_outs(), 48'd0);

      for (int i = 0; i < 5; i++) begin
         start(tbl[i]);
         wait_result(tbl[i], $sformatf("vec%0d", i), 0);
         handshake($sformatf("vec%0d", i));
      end

      for (int i = 0; i < 40; i++) begin
         v.q  = 8'($urandom);
         v.qf = ($urandom_range(7) != 0);
         v.kf = 4'($urandom);
         for (int k = 0; k < NK; k++) begin
            int t;
            t = int'(v.q) + int'($urandom_range(80)) - 40;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            v.kp[8*k +: 8] = v.kf[k] ? 8'(t) : PHASE_NOFIRE;
         end
         v = model(v);
         start(v);
         wait_result(v, "rand", 0);
         handshake("rand");
      end

      // Backpressure: hold out_ready low for 10 DONE clocks, cycle_start in the 3rd.
      start(tbl[0]);
      wait_result(tbl[0], "bp", 0);
      ovr = 0;
      for (int c = 1; c <= 9; c++) begin
         i_cycle_start = (c == 3);
         tick();
         ovr += int'(o_overrun);
         if (c == 3) chk("bp_overrun_pulse", 48'(o_overrun), 48'd1);
         chk("bp_valid_held", 48'(o_out_valid), 48'd1);
         chk("bp_bus_held", 48'(o_score_bus), 48'(tbl[0].sb));
      end
      i_cycle_start = 1'b0;
      chk("bp_overrun_count", 48'(ovr), 48'd1);
      chk("bp_best_held", 48'({o_best_idx, o_best_score}), 48'({tbl[0].idx, tbl[0].best}));
      handshake("bp");

      // cycle_start during SCAN is dropped and leaves the result intact.
      start(tbl[1]);
      tick();
      i_cycle_start = 1'b1;
      tick();
      i_cycle_start = 1'b0;
      chk("scan_overrun", 48'(o_overrun), 48'd1);
      wait_result(tbl[1], "scan_ovr", 2);
      chk("scan_overrun_clr", 48'(o_overrun), 48'd0);

      // Back-to-back: new cycle_start in the same clock as the handshake.
      i_q_phase = tbl[0].q;
      i_q_fired = tbl[0].qf;
      i_k_phase = tbl[0].kp;
      i_k_fired = tbl[0].kf;
      i_cycle_start = 1'b1;
      i_out_ready = 1'b1;
      tick();
      i_cycle_start = 1'b0;
      i_out_ready = 1'b0;
      scramble();
      chk("b2b_valid", 48'(o_out_valid), 48'd0);
      chk("b2b_busy", 48'(o_busy), 48'd1);
      chk("b2b_no_overrun", 48'(o_overrun), 48'd0);
      chk("b2b_bus_cleared", 48'(o_score_bus), 48'd0);
      wait_result(tbl[0], "b2b", 0);
      handshake("b2b");

      // Reset asserted with the scan index at 2.
      start(tbl[3]);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_scan", all_outs(), 48'd0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("rst_idle", all_outs(), 48'd0);
      start(tbl[1]);
      wait_result(tbl[1], "post_rst", 0);
      handshake("post_rst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
